// File: rtl/acondicionador_botones.sv
// Button conditioner: two-flop synchroniser, per-channel debounce FSM with press and
// long-press strobes, plus the B_Test flag toggled by a long press of channel TEST_IDX.
module acondicionador_botones #(
   parameter int NUM_BTN           = 3,
   parameter int DEBOUNCE_CYCLES   = 16,
   parameter int LONG_PRESS_CYCLES = 64,
   parameter int TEST_IDX          = 0
) (
   input  logic               clk,
   input  logic               B_Reset,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_pulse,
   output logic [NUM_BTN-1:0] btn_long,
   output logic               B_Test
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, DEB_UP, HELD, LONG, DEB_DN} state_t;

   function automatic logic [DW-1:0] deb_inc(input logic [DW-1:0] v);
      return (v == {DW{1'b1}}) ? v : v + 1'b1;
   endfunction

   function automatic logic [HW-1:0] hold_inc(input logic [HW-1:0] v);
      return (v == {HW{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic [NUM_BTN-1:0] sync1_q, sync2_q;
   logic               test_q;

   always_ff @(posedge clk) begin
      if (B_Reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      state_t        state_q, state_d;
      logic [DW-1:0] deb_q, deb_d;
      logic [HW-1:0] hold_q, hold_d;
      logic          pulse_q, pulse_d;
      logic          long_q, long_d;
      logic          s;

      assign s = sync2_q[g];

      always_ff @(posedge clk) begin
         if (B_Reset) begin
            state_q <= IDLE;
            deb_q   <= '0;
            hold_q  <= '0;
            pulse_q <= 1'b0;
            long_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
            long_q  <= long_d;
         end
      end

      always_comb begin
         state_d = state_q;
         deb_d   = deb_q;
         hold_d  = hold_q;
         pulse_d = 1'b0;
         long_d  = 1'b0;
         case (state_q)
            IDLE: begin
               if (s) begin
                  state_d = DEB_UP;
                  deb_d   = DW'(1);
               end
            end
            DEB_UP: begin
               if (!s) begin
                  state_d = IDLE;
                  deb_d   = '0;
               end else if (deb_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                  state_d = HELD;
                  deb_d   = '0;
                  hold_d  = '0;
                  pulse_d = 1'b1;
               end else begin
                  deb_d = deb_inc(deb_q);
               end
            end
            HELD: begin
               if (!s) begin
                  state_d = DEB_DN;
                  deb_d   = DW'(1);
               end else begin
                  hold_d = hold_inc(hold_q);
                  if (hold_q == HW'(LONG_PRESS_CYCLES - 1)) begin
                     state_d = LONG;
                     long_d  = 1'b1;
                  end
               end
            end
            LONG: begin
               if (!s) begin
                  state_d = DEB_DN;
                  deb_d   = DW'(1);
               end
            end
            DEB_DN: begin
               // hold_cnt only reaches LONG_PRESS_CYCLES once LONG was entered
               if (s) begin
                  state_d = (hold_q == HW'(LONG_PRESS_CYCLES)) ? LONG : HELD;
                  deb_d   = '0;
               end else if (deb_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                  state_d = IDLE;
                  deb_d   = '0;
               end else begin
                  deb_d = deb_inc(deb_q);
               end
            end
            default: begin
               state_d = IDLE;
               deb_d   = '0;
            end
         endcase
      end

      assign btn_level[g] = (state_q == HELD) || (state_q == LONG) || (state_q == DEB_DN);
      assign btn_pulse[g] = pulse_q;
      assign btn_long[g]  = long_q;
   end

   always_ff @(posedge clk) begin
      if (B_Reset) begin
         test_q <= 1'b0;
      end else if (btn_long[TEST_IDX]) begin
         test_q <= ~test_q;
      end
   end

   assign B_Test = test_q;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Directed bench for acondicionador_botones with a run-length debounce reference model
// compared on every falling edge, plus literal checks at hand-computed cycles.
module tb_acondicionador_botones;

   localparam int N    = 3;
   localparam int DEB  = 4;
   localparam int LNG  = 20;
   localparam int TIDX = 0;

   logic         clk = 1'b0;
   logic         B_Reset;
   logic [N-1:0] btn_raw;
   logic [N-1:0] btn_level, btn_pulse, btn_long;
   logic         B_Test;

   acondicionador_botones #(
      .NUM_BTN(N), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LNG), .TEST_IDX(TIDX)
   ) dut (
      .clk(clk), .B_Reset(B_Reset), .btn_raw(btn_raw),
      .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_long(btn_long), .B_Test(B_Test)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state: predicts DUT outputs after the next rising edge
   bit [N-1:0] m_r1, m_s, m_lvl, m_pulse, m_long;
   bit         m_bt;
   int         m_run[N];
   int         m_since[N];
   bit         m_clean[N];

   // cumulative observations of the DUT, taken at falling edges
   int n_pulse[N], n_long[N], n_hi[N], n_lo[N], n_rise[N];
   bit [N-1:0] prev_lvl;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_step();
      bit s_old;
      if (B_Reset) begin
         m_r1 = '0; m_s = '0; m_lvl = '0; m_pulse = '0; m_long = '0; m_bt = 1'b0;
         for (int c = 0; c < N; c++) begin
            m_run[c] = 0; m_since[c] = 0; m_clean[c] = 1'b0;
         end
      end else begin
         m_bt = m_bt ^ m_long[TIDX];
         for (int c = 0; c < N; c++) begin
            s_old      = m_s[c];
            m_pulse[c] = 1'b0;
            m_long[c]  = 1'b0;
            if (s_old != m_lvl[c]) m_run[c]++;
            else m_run[c] = 0;
            if (m_run[c] == DEB) begin
               m_lvl[c] = s_old;
               m_run[c] = 0;
               if (s_old) begin
                  m_pulse[c] = 1'b1;
                  m_since[c] = 0;
                  m_clean[c] = 1'b1;
               end
            end else if (m_lvl[c]) begin
               m_since[c]++;
               if (!s_old) m_clean[c] = 1'b0;
               if (m_since[c] == LNG && m_clean[c]) m_long[c] = 1'b1;
            end
         end
         m_s  = m_r1;
         m_r1 = btn_raw;
      end
   endtask

   task automatic monitor_cycle();
      chk("level", btn_level, m_lvl);
      chk("pulse", btn_pulse, m_pulse);
      chk("long", btn_long, m_long);
      chk("b_test", B_Test, m_bt);
      for (int c = 0; c < N; c++) begin
         n_pulse[c] += btn_pulse[c];
         n_long[c]  += btn_long[c];
         n_hi[c]    += btn_level[c];
         n_lo[c]    += !btn_level[c];
         n_rise[c]  += (btn_level[c] && !prev_lvl[c]);
      end
      prev_lvl = btn_level;
      model_step();
   endtask

   int sp, sl, sh, sr;

   initial begin
      B_Reset  = 1'b1;
      btn_raw  = 3'b111;
      prev_lvl = '0;
      for (int c = 0; c < N; c++) begin
         n_pulse[c] = 0; n_long[c] = 0; n_hi[c] = 0; n_lo[c] = 0; n_rise[c] = 0;
         m_run[c] = 0; m_since[c] = 0; m_clean[c] = 1'b0;
      end
      fork
         forever begin
            @(negedge clk);
            monitor_cycle();
         end
      join_none

      // 1: reset with all buttons held
      tick(3);
      chk("rst_level", btn_level, 0);
      chk("rst_pulse", btn_pulse, 0);
      chk("rst_long", btn_long, 0);
      chk("rst_btest", B_Test, 0);
      B_Reset = 1'b0;
      tick(5);
      chk("t1_level_c5", btn_level, 3'b000);
      tick(1);
      chk("t1_level_c6", btn_level, 3'b111);
      chk("t1_pulse_c6", btn_pulse, 3'b111);
      tick(1);
      chk("t1_pulse_c7", btn_pulse, 3'b000);
      btn_raw = 3'b000;
      tick(10);
      chk("t1_released", btn_level, 3'b000);

      // 2: bounce on channel 1
      sp = n_pulse[1]; sr = n_rise[1];
      btn_raw = 3'b010; tick(1);
      btn_raw = 3'b000; tick(1);
      btn_raw = 3'b010; tick(1);
      btn_raw = 3'b000; tick(1);
      btn_raw = 3'b010;
      tick(5);
      chk("t2_level_c5", btn_level[1], 0);
      tick(1);
      chk("t2_level_c6", btn_level[1], 1);
      chk("t2_pulse_c6", btn_pulse[1], 1);
      btn_raw = 3'b000;
      tick(10);
      chk("t2_pulse_count", n_pulse[1] - sp, 1);
      chk("t2_rise_count", n_rise[1] - sr, 1);

      // 3: short press on channel 2
      sp = n_pulse[2]; sl = n_long[2]; sh = n_hi[2];
      btn_raw = 3'b100; tick(10);
      btn_raw = 3'b000; tick(12);
      chk("t3_high_cycles", n_hi[2] - sh, 10);
      chk("t3_pulse_count", n_pulse[2] - sp, 1);
      chk("t3_long_count", n_long[2] - sl, 0);

      // 4: long press on channel 0 toggles B_Test
      sp = n_pulse[0]; sl = n_long[0];
      btn_raw = 3'b001;
      tick(6);
      chk("t4_pulse_c6", btn_pulse[0], 1);
      tick(19);
      chk("t4_long_c25", btn_long[0], 0);
      tick(1);
      chk("t4_long_c26", btn_long[0], 1);
      chk("t4_btest_c26", B_Test, 0);
      tick(1);
      chk("t4_long_c27", btn_long[0], 0);
      chk("t4_btest_c27", B_Test, 1);
      tick(13);
      btn_raw = 3'b000;
      tick(10);
      chk("t4_long_count", n_long[0] - sl, 1);
      chk("t4_pulse_count", n_pulse[0] - sp, 1);
      btn_raw = 3'b001;
      tick(27);
      chk("t4_btest_second", B_Test, 0);

      // 5: two-cycle release glitch while in LONG
      sp = n_pulse[0]; sl = n_long[0]; sh = n_lo[0];
      btn_raw = 3'b000; tick(2);
      btn_raw = 3'b001; tick(12);
      chk("t5_low_cycles", n_lo[0] - sh, 0);
      chk("t5_pulse_count", n_pulse[0] - sp, 0);
      chk("t5_long_count", n_long[0] - sl, 0);
      chk("t5_level", btn_level[0], 1);
      btn_raw = 3'b000;
      tick(10);

      // 6: reset mid-press with B_Test set
      btn_raw = 3'b001;
      tick(27);
      chk("t6_btest_set", B_Test, 1);
      btn_raw = 3'b000;
      tick(10);
      btn_raw = 3'b001;
      tick(16);
      chk("t6_level_held", btn_level[0], 1);
      B_Reset = 1'b1;
      tick(1);
      chk("t6_rst_level", btn_level, 0);
      chk("t6_rst_btest", B_Test, 0);
      chk("t6_rst_pulse", btn_pulse, 0);
      B_Reset = 1'b0;
      tick(5);
      chk("t6_level_c5", btn_level[0], 0);
      tick(1);
      chk("t6_pulse_c6", btn_pulse[0], 1);
      btn_raw = 3'b000;
      tick(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
